// File: rtl/mem_access_wb_pkg.sv
// mem_access_wb_pkg: shared FSM states, MEM/WB writeback bundle and bubble constant
package mem_access_wb_pkg;
  localparam int PKG_DATA_W = 32;
  localparam int PKG_RD_W   = 5;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [PKG_DATA_W-1:0] read_data;
    logic [PKG_DATA_W-1:0] alu_data;
    logic [PKG_RD_W-1:0]   rd;
  } mem_wb_t;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;
endpackage

// File: rtl/mem_access_wb_mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; loads i_d each edge, or a bubble when i_bubble
// Ports: clk_i/rst_i (async active-low), i_bubble, i_d (next bundle), o_q (registered bundle)
module mem_wb_reg
  import mem_access_wb_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    i_bubble,
  input  mem_wb_t i_d,
  output mem_wb_t o_q
);
  mem_wb_t r_q;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_q <= MEM_WB_BUBBLE;
    else        r_q <= i_bubble ? MEM_WB_BUBBLE : i_d;
  assign o_q = r_q;
endmodule

// File: rtl/mem_access_wb.sv
// mem_access_wb: MEM stage with req/gnt + rvalid data-memory handshake, stall, timeout and MEM/WB register
// Ports: clk_i/rst_i (async active-low); EX/MEM inputs RegWrite/MemtoReg/MemRead/MemWrite/data/Writedata/rd;
//        stall_o to upstream; dmem_* request/response channel; MEM/WB outputs; sticky dmem_err_o
module mem_access_wb
  import mem_access_wb_pkg::*;
#(
  parameter int DATA_W  = PKG_DATA_W,
  parameter int RD_W    = PKG_RD_W,
  parameter int TIMEOUT = 255
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] Writedata_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] ReadData_o,
  output logic [DATA_W-1:0] ALUdata_o,
  output logic [RD_W-1:0]   rd_o,
  output logic              dmem_err_o
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we, r_err;
  logic [DATA_W-1:0] r_addr, r_wdata, r_rdata, w_cap_data;
  logic              w_mem_op, w_timeout, w_stall, w_latch, w_cap, w_abort, w_bubble;
  mem_wb_t           w_wb, w_q;
  assign w_mem_op  = MemRead_i | MemWrite_i;
  // the current REQ/WAIT cycle is the TIMEOUT-th one spent on this access
  assign w_timeout = r_cnt == CNT_W'(TIMEOUT - 1);
  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b1;
    w_latch    = 1'b0;
    w_cap      = 1'b0;
    w_cap_data = '0;
    w_abort    = 1'b0;
    w_bubble   = 1'b1;
    case (r_state)
      IDLE: begin
        w_stall  = w_mem_op;
        w_latch  = w_mem_op;
        w_bubble = w_mem_op;
        w_next   = w_mem_op ? REQ : IDLE;
      end
      REQ:
        if (dmem_gnt_i && dmem_rvalid_i) begin
          w_cap      = 1'b1;
          w_cap_data = r_we ? '0 : dmem_rdata_i;
          w_next     = DONE;
        end else if (w_timeout) begin
          w_cap   = 1'b1;
          w_abort = 1'b1;
          w_next  = DONE;
        end else if (dmem_gnt_i) w_next = WAIT;
      WAIT:
        if (dmem_rvalid_i) begin
          w_cap      = 1'b1;
          w_cap_data = r_we ? '0 : dmem_rdata_i;
          w_next     = DONE;
        end else if (w_timeout) begin
          w_cap   = 1'b1;
          w_abort = 1'b1;
          w_next  = DONE;
        end
      default: begin
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        w_next   = IDLE;
      end
    endcase
    w_wb.reg_write  = RegWrite_i;
    w_wb.mem_to_reg = MemtoReg_i;
    w_wb.read_data  = (r_state == DONE) ? r_rdata : '0;
    w_wb.alu_data   = data_i;
    w_wb.rd         = rd_i;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= ((r_state == REQ || r_state == WAIT) && w_next != DONE) ? r_cnt + CNT_W'(1) : '0;
      if (w_latch) begin
        r_addr  <= data_i;
        r_wdata <= Writedata_i;
        r_we    <= MemWrite_i;
      end
      if (w_cap) r_rdata <= w_cap_data;
      if (w_abort) r_err <= 1'b1;
    end
  mem_wb_reg u_mem_wb_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_bubble (w_bubble),
    .i_d      (w_wb),
    .o_q      (w_q)
  );
  // stall is combinational in IDLE, so it is gated by reset to drop immediately
  assign stall_o      = rst_i & w_stall;
  assign dmem_req_o   = r_state == REQ;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign dmem_err_o   = r_err;
  assign RegWrite_o   = w_q.reg_write;
  assign MemtoReg_o   = w_q.mem_to_reg;
  assign ReadData_o   = w_q.read_data;
  assign ALUdata_o    = w_q.alu_data;
  assign rd_o         = w_q.rd;
endmodule

// File: tb/tb_mem_access_wb.sv
// tb_mem_access_wb: scoreboard bench for mem_access_wb with a configurable memory responder
module tb_mem_access_wb;
  logic        clk = 0, rst_n = 0;
  logic        reg_write, mem_to_reg, mem_read, mem_write;
  logic [31:0] data, wdata;
  logic [4:0]  rd;
  logic        stall, req, we, gnt = 0, rvalid = 0, err;
  logic [31:0] addr, dm_wdata, rdata = 0;
  logic        rw_o, m2r_o;
  logic [31:0] rdata_o, alu_o;
  logic [4:0]  rd_o;
  int checks = 0, errors = 0;
  typedef struct {logic rw; logic m2r; logic [31:0] rdd; logic [31:0] alu; logic [4:0] rd;} wb_t;
  wb_t sb_q[$];
  wb_t e;
  bit  in_valid = 0, fire = 0;
  int  gnt_dly = -1, rv_dly = 0, req_cnt = 0, wait_cnt = 0, hs = 0, last_run = 0;
  logic [31:0] cfg_rdata = 0, exp_addr = 0, exp_wdata = 0;
  logic exp_we = 0;
  always #5 clk = ~clk;
  mem_access_wb #(.TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .RegWrite_i(reg_write), .MemtoReg_i(mem_to_reg), .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .data_i(data), .Writedata_i(wdata), .rd_i(rd),
    .stall_o(stall), .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(dm_wdata),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .RegWrite_o(rw_o), .MemtoReg_o(m2r_o), .ReadData_o(rdata_o), .ALUdata_o(alu_o), .rd_o(rd_o),
    .dmem_err_o(err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    gnt    = 0;
    rvalid = 0;
    rdata  = $urandom;
    if (req) begin
      check("req_addr", addr, exp_addr);
      check("req_we", we, exp_we);
      if (exp_we) check("req_wdata", dm_wdata, exp_wdata);
      if (req_cnt == gnt_dly) begin
        gnt = 1;
        hs++;
        if (rv_dly == 0) begin
          rvalid = 1;
          rdata  = cfg_rdata;
        end else wait_cnt = rv_dly;
      end
      req_cnt++;
      last_run = req_cnt;
    end else begin
      req_cnt = 0;
      if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          rvalid = 1;
          rdata  = cfg_rdata;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (fire) begin
      if (sb_q.size() == 0) check("wb_unexpected", 1, 0);
      else begin
        e = sb_q.pop_front();
        check("wb_regwrite", rw_o, e.rw);
        check("wb_memtoreg", m2r_o, e.m2r);
        check("wb_readdata", rdata_o, e.rdd);
        check("wb_aludata", alu_o, e.alu);
        check("wb_rd", rd_o, e.rd);
      end
    end else check("bubble_regwrite", rw_o, 0);
    fire = in_valid && !stall;
  end
  task automatic drive(input logic rw, m2r, mr, mw, input logic [31:0] a, wd, input logic [4:0] r);
    reg_write = rw; mem_to_reg = m2r; mem_read = mr; mem_write = mw;
    data = a; wdata = wd; rd = r;
  endtask
  task automatic idle();
    in_valid = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic issue(input logic rw, m2r, mr, mw, input logic [31:0] a, wd, input logic [4:0] r,
                       input int gd, rvd, input logic [31:0] rdat, input bit to, output int st);
    gnt_dly = gd; rv_dly = rvd; cfg_rdata = rdat;
    exp_addr = a; exp_wdata = wd; exp_we = mw;
    drive(rw, m2r, mr, mw, a, wd, r);
    in_valid = 1;
    sb_q.push_back('{rw, m2r, ((mr | mw) && !mw && !to) ? rdat : 32'h0, a, r});
    st = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      st++;
      if (st > 40) begin
        check("stall_bound", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int st, h0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_req", req, 0);
    check("rst_regwrite", rw_o, 0);
    check("rst_readdata", rdata_o, 0);
    check("rst_err", err, 0);
    check("rst_addr", addr, 0);
    rst_n = 1;
    @(posedge clk); #1;
    issue(1, 0, 0, 0, 32'h10, 0, 5, -1, 0, 0, 0, st);
    check("alu_stalls", st, 0);
    idle();
    issue(1, 1, 1, 0, 32'h40, 0, 3, 0, 0, 32'hDEADBEEF, 0, st);
    check("load_stalls", st, 2);
    idle();
    issue(0, 0, 0, 1, 32'h80, 32'h1234, 0, 3, 2, 32'hFFFFFFFF, 0, st);
    check("store_stalls", st, 7);
    idle();
    h0 = hs;
    issue(1, 1, 1, 0, 32'h44, 0, 8, 0, 0, 32'hA5A50001, 0, st);
    check("b2b_load1_stalls", st, 2);
    issue(1, 1, 1, 0, 32'h48, 0, 9, 1, 1, 32'h5A5A0002, 0, st);
    check("b2b_load2_stalls", st, 4);
    idle();
    repeat (2) @(negedge clk);
    check("b2b_handshakes", hs - h0, 2);
    check("err_before_timeout", err, 0);
    @(posedge clk); #1;
    issue(1, 1, 1, 0, 32'hC0, 0, 10, -1, 0, 32'h1111, 1, st);
    check("timeout_stalls", st, 9);
    idle();
    repeat (2) @(negedge clk);
    check("timeout_req_cycles", last_run, 8);
    check("timeout_err", err, 1);
    @(posedge clk); #1;
    issue(1, 0, 0, 0, 32'h20, 0, 6, -1, 0, 0, 0, st);
    check("post_timeout_alu_stalls", st, 0);
    idle();
    repeat (2) @(negedge clk);
    check("err_sticky", err, 1);
    @(posedge clk); #1;
    gnt_dly = 0; rv_dly = 6; cfg_rdata = 32'hCAFEF00D;
    exp_addr = 32'h100; exp_we = 0;
    drive(1, 1, 1, 0, 32'h100, 0, 7);
    in_valid = 1;
    repeat (3) @(negedge clk);
    check("pre_rst_stall", stall, 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_stall", stall, 0);
    check("async_rst_req", req, 0);
    check("async_rst_regwrite", rw_o, 0);
    check("async_rst_addr", addr, 0);
    check("async_rst_err", err, 0);
    idle();
    @(posedge clk); #1;
    rst_n = 1;
    repeat (8) @(negedge clk);
    check("late_rvalid_req", req, 0);
    check("late_rvalid_stall", stall, 0);
    check("late_rvalid_readdata", rdata_o, 0);
    check("late_rvalid_err", err, 0);
    @(posedge clk); #1;
    issue(1, 0, 0, 0, 32'h33, 0, 12, -1, 0, 0, 0, st);
    check("post_rst_alu_stalls", st, 0);
    idle();
    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
